// File: rtl/down_counter_sequencer.sv
// down_counter_sequencer
// Queues start values from a valid/ready client and runs one job at a time on an
// external parallel-load T-FF down counter. Each job runs clear -> load -> count -> done.
// A zero start value completes immediately without touching the counter.
// A watchdog flags a job that does not complete within TIMEOUT count cycles; the error
// holds the counter in clear until abort.
// Outputs are registered. They are computed from the next state, so each one matches
// the state that is current on the same cycle.
module down_counter_sequencer #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    input  logic [WIDTH-1:0]                 req_value,
    output logic                             req_ready,
    input  logic                             abort,
    output logic [WIDTH-1:0]                 cnt_in,
    output logic                             cnt_select,
    output logic                             cnt_reset,
    input  logic [WIDTH-1:0]                 cnt_out,
    input  logic                             cnt_cmpltd,
    output logic                             busy,
    output logic                             done,
    output logic [WIDTH-1:0]                 done_value,
    output logic [$clog2(TIMEOUT+1)-1:0]     done_cycles,
    output logic                             err_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_COUNT = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Counter value is observed for debug only; it never steers control.
    logic             w_unused_cnt_out;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] w_cur_nxt;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_inc;

    logic             w_cnt_reset_nxt;
    logic             w_cnt_select_nxt;
    logic [WIDTH-1:0] w_cnt_in_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_done_value_nxt;
    logic [TW-1:0]    w_done_cycles_nxt;

    logic             r_cnt_reset;
    logic             r_cnt_select;
    logic [WIDTH-1:0] r_cnt_in;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_done_value;
    logic [TW-1:0]    r_done_cycles;

    assign w_unused_cnt_out = ^cnt_out;

    // Ready depends only on the registered occupancy. A pop in the same cycle does not
    // free a slot early.
    assign req_ready = (r_count != CW'(DEPTH));
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_head    = r_mem[r_rptr];

    // FIFO storage: written on every accepted request.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= req_value;
        end
    end

    // FIFO pointers and occupancy. A reset drops every queued entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Job sequencing FSM
    // ------------------------------------------------------------------
    assign w_timer_inc = r_timer + TW'(1);
    assign w_cur_nxt   = w_pop ? w_head : r_cur;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Abort outranks completion and timeout in the active states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = (w_head == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = abort ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = abort ? S_IDLE : S_COUNT;
            end
            S_COUNT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (cnt_cmpltd) begin
                    w_state_nxt = S_DONE;
                end else if (w_timer_inc == TW'(TIMEOUT)) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Job value and watchdog timer. The timer restarts in LOAD and runs through COUNT.
    always_ff @(posedge clk) begin
        r_cur <= w_cur_nxt;
        if (r_state == S_LOAD) begin
            r_timer <= '0;
        end else if (r_state == S_COUNT) begin
            r_timer <= w_timer_inc;
        end
    end

    // Output decode for the state being entered.
    always_comb begin
        w_cnt_reset_nxt   = !((w_state_nxt == S_CLEAR) || (w_state_nxt == S_ERR));
        w_cnt_select_nxt  = (w_state_nxt == S_LOAD);
        w_cnt_in_nxt      = (w_state_nxt == S_LOAD) ? w_cur_nxt : '0;
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_done_nxt        = (w_state_nxt == S_DONE);
        w_err_nxt         = (w_state_nxt == S_ERR);
        w_done_value_nxt  = r_done_value;
        w_done_cycles_nxt = r_done_cycles;
        if (w_state_nxt == S_DONE) begin
            w_done_value_nxt = w_cur_nxt;
            // A zero job reaches DONE straight from IDLE and spends no cycles counting.
            w_done_cycles_nxt = (r_state == S_COUNT) ? w_timer_inc : '0;
        end
    end

    // Output registers. Reset holds the counter in clear and zeroes every report.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt_reset   <= 1'b0;
            r_cnt_select  <= 1'b0;
            r_cnt_in      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_done_value  <= '0;
            r_done_cycles <= '0;
        end else begin
            r_cnt_reset   <= w_cnt_reset_nxt;
            r_cnt_select  <= w_cnt_select_nxt;
            r_cnt_in      <= w_cnt_in_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_done_value  <= w_done_value_nxt;
            r_done_cycles <= w_done_cycles_nxt;
        end
    end

    assign cnt_reset   = r_cnt_reset;
    assign cnt_select  = r_cnt_select;
    assign cnt_in      = r_cnt_in;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_timeout = r_err;
    assign done_value  = r_done_value;
    assign done_cycles = r_done_cycles;

endmodule

// File: tb/tb_down_counter_sequencer.sv
// Bench for down_counter_sequencer.
// It contains a behavioural parallel-load down counter and a job-level reference model.
module tb_down_counter_sequencer;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 20;
    localparam int TW      = $clog2(TIMEOUT + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic [WIDTH-1:0] req_value = '0;
    logic             req_ready;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_select;
    logic             cnt_reset;
    logic [WIDTH-1:0] cnt_out;
    logic             cnt_cmpltd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] done_value;
    logic [TW-1:0]    done_cycles;
    logic             err_timeout;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    down_counter_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .abort      (abort),
        .cnt_in     (cnt_in),
        .cnt_select (cnt_select),
        .cnt_reset  (cnt_reset),
        .cnt_out    (cnt_out),
        .cnt_cmpltd (cnt_cmpltd),
        .busy       (busy),
        .done       (done),
        .done_value (done_value),
        .done_cycles(done_cycles),
        .err_timeout(err_timeout)
    );

    // Behavioural T-FF down counter. Clear is active-low, select loads cnt_in, and
    // otherwise the counter steps down and stops at zero. The terminal-count flag is
    // high in the cycle whose closing edge takes the count to zero. 'stall' models a
    // broken counter that never reports completion.
    logic [WIDTH-1:0] m_q = '0;
    bit               stall = 1'b0;

    always @(posedge clk) begin
        if (!cnt_reset)       m_q <= '0;
        else if (cnt_select)  m_q <= cnt_in;
        else if (m_q != '0)   m_q <= m_q - 1'b1;
    end

    assign cnt_out    = m_q;
    assign cnt_cmpltd = !stall && cnt_reset && !cnt_select && (m_q == WIDTH'(1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for three consecutive non-busy cycles with the FIFO able to accept.
    task automatic wait_quiet();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 300) begin
            tick();
            n++;
            if (!busy && req_ready) quiet++;
            else quiet = 0;
        end
        check("wait_quiet_timeout", (quiet >= 3), 1);
    endtask

    // Presents one request and holds it until the edge that accepts it.
    task automatic push_one(input logic [WIDTH-1:0] v);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready_timeout", req_ready, 1);
        req_valid = 1'b1;
        req_value = v;
        tick();
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [WIDTH-1:0] value;
        int               exp_cycles;
        int               exp_lat;
    } vec_t;

    vec_t tbl[5];

    // Job-level reference model for the random phase.
    int mq[$];
    int m_rem;
    int m_cur;
    int m_dv;
    int m_dc;

    initial begin
        int lat;
        int k;
        bit seen;
        bit toggled;
        logic [WIDTH-1:0] got[$];
        bit exp_push;

        // Each row gives the start value, its count cycles, and the edges from push to done.
        tbl[0] = '{4'hF, 15, 18};
        tbl[1] = '{4'h1, 1, 4};
        tbl[2] = '{4'h0, 0, 1};
        tbl[3] = '{4'h7, 7, 10};
        tbl[4] = '{4'hA, 10, 13};

        // Hold reset for two cycles.
        reset = 1'b0;
        tick();
        tick();
        check("rst_cnt_reset", cnt_reset, 0);
        check("rst_cnt_select", cnt_select, 0);
        check("rst_cnt_in", cnt_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_value", done_value, 0);
        check("rst_done_cycles", done_cycles, 0);
        check("rst_err", err_timeout, 0);
        check("rst_req_ready", req_ready, 1);
        reset = 1'b1;
        tick();
        check("idle_cnt_reset", cnt_reset, 1);
        check("idle_busy", busy, 0);

        // A job of value F clears for one cycle, then loads F and counts down 15 cycles.
        wait_quiet();
        push_one(4'hF);
        tick();
        check("clear_cnt_reset", cnt_reset, 0);
        check("clear_busy", busy, 1);
        tick();
        check("load_cnt_reset", cnt_reset, 1);
        check("load_cnt_select", cnt_select, 1);
        check("load_cnt_in", cnt_in, 4'hF);
        tick();
        check("count_cnt_select", cnt_select, 0);
        k = 0;
        while (!done && k < 60) begin
            tick();
            k++;
        end
        check("F_count_cycles", k, 15);
        check("F_done_value", done_value, 4'hF);
        check("F_done_cycles", done_cycles, 15);

        // Table of single jobs: latency, reported values, one-cycle pulse.
        for (int i = 0; i < 5; i++) begin
            wait_quiet();
            push_one(tbl[i].value);
            lat = 0;
            seen = 0;
            toggled = 0;
            while (!seen && lat < 60) begin
                tick();
                lat++;
                if (cnt_reset !== 1'b1 || cnt_select !== 1'b0) toggled = 1;
                if (done) seen = 1;
            end
            check("tbl_done_seen", seen, 1);
            check("tbl_latency", lat, tbl[i].exp_lat);
            check("tbl_done_value", done_value, tbl[i].value);
            check("tbl_done_cycles", done_cycles, tbl[i].exp_cycles);
            tick();
            check("tbl_done_pulse", done, 0);
            check("tbl_value_held", done_value, tbl[i].value);
            if (tbl[i].value == 0) check("zero_no_counter_toggle", toggled, 0);
        end

        // Jobs F, A and 3 pushed back to back fill the FIFO and complete in order.
        wait_quiet();
        push_one(4'hF);
        push_one(4'hA);
        push_one(4'h3);
        check("full_ready_low", req_ready, 0);
        got.delete();
        k = 0;
        while (got.size() < 3 && k < 200) begin
            tick();
            k++;
            if (done) got.push_back(done_value);
        end
        check("order_count", got.size(), 3);
        if (got.size() == 3) begin
            check("order_0", got[0], 4'hF);
            check("order_1", got[1], 4'hA);
            check("order_2", got[2], 4'h3);
        end

        // Watchdog: the counter never completes, the queued job waits, and abort recovers.
        wait_quiet();
        stall = 1'b1;
        push_one(4'h5);
        k = 0;
        while (!err_timeout && k < 80) begin
            tick();
            k++;
        end
        check("err_latency", k, 23);
        check("err_cnt_reset", cnt_reset, 0);
        check("err_busy", busy, 1);
        push_one(4'hA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_sticky", err_timeout, 1);
            check("err_cnt_reset_held", cnt_reset, 0);
            check("err_no_done", done, 0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        stall = 1'b0;
        check("abort_err_clear", err_timeout, 0);
        check("abort_busy", busy, 0);
        k = 0;
        while (!done && k < 60) begin
            tick();
            k++;
        end
        check("after_abort_done", done, 1);
        check("after_abort_value", done_value, 4'hA);
        check("after_abort_cycles", done_cycles, 10);

        // Reset in the middle of counting discards the job and the queued entry.
        wait_quiet();
        push_one(4'h9);
        repeat (6) tick();
        push_one(4'h4);
        reset = 1'b0;
        tick();
        check("midrst_cnt_reset", cnt_reset, 0);
        check("midrst_cnt_select", cnt_select, 0);
        check("midrst_cnt_in", cnt_in, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done_value", done_value, 0);
        check("midrst_done_cycles", done_cycles, 0);
        check("midrst_req_ready", req_ready, 1);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || done) seen = 1;
        end
        check("midrst_queue_dropped", seen, 0);

        // Random traffic compared against the job-level model. A job of value V holds
        // busy for V+3 cycles with done in the last one; a zero job takes one cycle.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mq.delete();
        m_rem = 0;
        m_cur = 0;
        m_dv = 0;
        m_dc = 0;
        for (int c = 0; c < 800; c++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_value = WIDTH'($urandom_range(0, 15));
            exp_push  = req_valid && (mq.size() < DEPTH);
            @(posedge clk);
            if (m_rem == 0 && mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_rem = (m_cur == 0) ? 1 : m_cur + 3;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (exp_push) mq.push_back(int'(req_value));
            if (m_rem == 1) begin
                m_dv = m_cur;
                m_dc = m_cur;
            end
            #1;
            check("rnd_ready", req_ready, (mq.size() < DEPTH));
            check("rnd_busy", busy, (m_rem > 0));
            check("rnd_done", done, (m_rem == 1));
            check("rnd_done_value", done_value, m_dv);
            check("rnd_done_cycles", done_cycles, m_dc);
        end
        req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
